motor_drive: RTL and testbench

// - Converts the 3-bit drive_state command from the mode FSM into per-wheel PWM + direction for the L/R motor H-bridges.
// - Sits directly downstream of the mode FSM. Ramps duty smoothly, and always passes through zero duty before a wheel reverses.
// - Hard-stops both wheels on the FSM's mode-change pulse.

---
 rtl/drive_pkg.sv | 32 +++
 rtl/motor_wheel_ramp.sv | 101 ++++++++++
 rtl/motor_drive.sv | 124 ++++++++++++
 tb/tb_motor_drive.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared definitions for the motor drive slice: the drive command codes used
// by the mode FSM, the per-wheel ramp states and the default duty constants.
package drive_pkg;

    // Command codes produced by the mode FSM; 110 and 111 are unused and mean STOP.
    typedef enum logic [2:0] {
        STOP   = 3'b000,
        LEFT   = 3'b001,
        RIGHT  = 3'b010,
        SLOW   = 3'b011,
        MEDIUM = 3'b100,
        FAST   = 3'b101
    } drive_state_t;

    // Per-wheel ramp controller states.
    typedef enum logic [2:0] {
        STOPPED = 3'd0,
        ACCEL   = 3'd1,
        CRUISE  = 3'd2,
        DECEL   = 3'd3,
        FLIP    = 3'd4
    } wheel_state_t;

    localparam int PWM_PERIOD_DEF  = 2500;  // 20 kHz at 50 MHz
    localparam int DUTY_W_DEF      = 12;
    localparam int TURN_DUTY_DEF   = 1000;
    localparam int SLOW_DUTY_DEF   = 750;
    localparam int MEDIUM_DUTY_DEF = 1500;
    localparam int FAST_DUTY_DEF   = 2250;
    localparam int RAMP_STEP_DEF   = 25;

endpackage

// File: rtl/motor_wheel_ramp.sv
// Per-wheel ramp controller: owns the duty magnitude and direction of one
// wheel and moves them toward the commanded target only at PWM period
// boundaries. A reversal always decelerates to zero, then spends one full
// period at zero with the new direction (FLIP) before accelerating again.
// Optional feature macro: MOTOR_DRIVE_SOFT_START_EN (defined = ramp limited to
// RAMP_STEP per period; undefined = jump straight to target at a boundary).
module motor_wheel_ramp
    import drive_pkg::*;
#(
    parameter int DUTY_W    = DUTY_W_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              boundary,
    input  logic              mode_change,
    input  logic [DUTY_W-1:0] tgt_mag,
    input  logic              tgt_dir,
    output logic [DUTY_W-1:0] mag,
    output logic              dir,
    output logic              on_target
);

`ifdef MOTOR_DRIVE_SOFT_START_EN
    localparam bit SOFT_START = 1'b1;
`else
    localparam bit SOFT_START = 1'b0;
`endif
    // Without soft start the step limit is the whole counter range, i.e. unbounded.
    localparam logic [DUTY_W-1:0] STEP_LIM = SOFT_START ? DUTY_W'(RAMP_STEP) : '1;

    wheel_state_t      state_reg, state_next;
    logic [DUTY_W-1:0] mag_reg, mag_next;
    logic              dir_reg, dir_next;
    logic              same_sign;
    logic [DUTY_W-1:0] goal, diff, delta, stepped;

    // One bounded step toward the goal: the target when it agrees with the
    // current direction, otherwise zero (a reversal must pass through zero).
    always_comb begin
        same_sign = (tgt_mag != '0) && (tgt_dir == dir_reg);
        goal      = same_sign ? tgt_mag : '0;
        diff      = (mag_reg > goal) ? (mag_reg - goal) : (goal - mag_reg);
        delta     = (diff > STEP_LIM) ? STEP_LIM : diff;
        stepped   = (mag_reg > goal) ? (mag_reg - delta) : (mag_reg + delta);
    end

    // Next-state logic: hard stop on mode_change, otherwise act only at a boundary.
    always_comb begin
        state_next = state_reg;
        mag_next   = mag_reg;
        dir_next   = dir_reg;
        if (mode_change) begin
            state_next = STOPPED;
            mag_next   = '0;
        end else if (boundary) begin
            case (state_reg)
                STOPPED, FLIP: begin
                    if (tgt_mag == '0) begin
                        state_next = STOPPED;
                    end else if (!same_sign) begin
                        dir_next   = ~dir_reg;
                        state_next = FLIP;
                    end else begin
                        mag_next   = stepped;
                        state_next = (stepped == goal) ? CRUISE : ACCEL;
                    end
                end
                default: begin
                    mag_next = stepped;
                    if (stepped == '0)
                        state_next = STOPPED;
                    else if (stepped == goal)
                        state_next = CRUISE;
                    else if (stepped < goal)
                        state_next = ACCEL;
                    else
                        state_next = DECEL;
                end
            endcase
        end
    end

    // State, magnitude and direction registers.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= STOPPED;
            mag_reg   <= '0;
            dir_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            mag_reg   <= mag_next;
            dir_reg   <= dir_next;
        end
    end

    assign mag       = mag_reg;
    assign dir       = dir_reg;
    assign on_target = (mag_reg == tgt_mag) && ((dir_reg == tgt_dir) || (tgt_mag == '0));

endmodule

// File: rtl/motor_drive.sv
// Motor drive top: registers the drive command from the mode FSM, decodes it
// into per-wheel targets, runs the shared PWM period counter and produces the
// registered PWM outputs. mode_change hard-stops both wheels immediately.
// Optional feature macro: MOTOR_DRIVE_SOFT_START_EN (see motor_wheel_ramp).
module motor_drive
    import drive_pkg::*;
#(
    parameter int PWM_PERIOD  = PWM_PERIOD_DEF,
    parameter int DUTY_W      = DUTY_W_DEF,
    parameter int TURN_DUTY   = TURN_DUTY_DEF,
    parameter int SLOW_DUTY   = SLOW_DUTY_DEF,
    parameter int MEDIUM_DUTY = MEDIUM_DUTY_DEF,
    parameter int FAST_DUTY   = FAST_DUTY_DEF,
    parameter int RAMP_STEP   = RAMP_STEP_DEF
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic [2:0] drive_state,
    input  logic       mode_change,
    output logic       left_pwm,
    output logic       left_dir,
    output logic       right_pwm,
    output logic       right_dir,
    output logic       at_target
);

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W-1:0] TURN_M   = DUTY_W'(TURN_DUTY);
    localparam logic [DUTY_W-1:0] SLOW_M   = DUTY_W'(SLOW_DUTY);
    localparam logic [DUTY_W-1:0] MEDIUM_M = DUTY_W'(MEDIUM_DUTY);
    localparam logic [DUTY_W-1:0] FAST_M   = DUTY_W'(FAST_DUTY);

    drive_state_t      ds_reg;
    logic [DUTY_W-1:0] cnt_reg;
    logic              boundary;
    logic [1:0]        pwm_reg, pwm_next;
    logic              at_target_reg;

    // Index 0 is the left wheel, index 1 the right wheel.
    logic [DUTY_W-1:0] tgt_mag   [2];
    logic              tgt_dir   [2];
    logic [DUTY_W-1:0] wheel_mag [2];
    logic              wheel_dir [2];
    logic              wheel_ok  [2];

    assign boundary = (cnt_reg == CNT_LAST);

    // Decode the registered command into magnitude and direction per wheel.
    always_comb begin
        tgt_mag[0] = '0;
        tgt_mag[1] = '0;
        tgt_dir[0] = 1'b1;
        tgt_dir[1] = 1'b1;
        case (ds_reg)
            LEFT: begin
                tgt_mag[0] = TURN_M;
                tgt_mag[1] = TURN_M;
                tgt_dir[0] = 1'b0;
            end
            RIGHT: begin
                tgt_mag[0] = TURN_M;
                tgt_mag[1] = TURN_M;
                tgt_dir[1] = 1'b0;
            end
            SLOW: begin
                tgt_mag[0] = SLOW_M;
                tgt_mag[1] = SLOW_M;
            end
            MEDIUM: begin
                tgt_mag[0] = MEDIUM_M;
                tgt_mag[1] = MEDIUM_M;
            end
            FAST: begin
                tgt_mag[0] = FAST_M;
                tgt_mag[1] = FAST_M;
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wheel
            motor_wheel_ramp #(
                .DUTY_W    (DUTY_W),
                .RAMP_STEP (RAMP_STEP)
            ) u_ramp (
                .clk_50      (clk_50),
                .reset_n     (reset_n),
                .boundary    (boundary),
                .mode_change (mode_change),
                .tgt_mag     (tgt_mag[gi]),
                .tgt_dir     (tgt_dir[gi]),
                .mag         (wheel_mag[gi]),
                .dir         (wheel_dir[gi]),
                .on_target   (wheel_ok[gi])
            );
            // A mode change forces the output low on the very next cycle.
            assign pwm_next[gi] = !mode_change && (cnt_reg < wheel_mag[gi]);
        end
    endgenerate

    // Command register, period counter, PWM outputs and at_target flag.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            ds_reg        <= STOP;
            cnt_reg       <= '0;
            pwm_reg       <= '0;
            at_target_reg <= 1'b1;
        end else begin
            ds_reg        <= drive_state_t'(drive_state);
            cnt_reg       <= boundary ? '0 : cnt_reg + 1'b1;
            pwm_reg       <= pwm_next;
            at_target_reg <= wheel_ok[0] && wheel_ok[1];
        end
    end

    assign left_pwm  = pwm_reg[0];
    assign right_pwm = pwm_reg[1];
    assign left_dir  = wheel_dir[0];
    assign right_dir = wheel_dir[1];
    assign at_target = at_target_reg;

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive with a shortened PWM period so that every
// ramp fits in a few thousand cycles. Duty is observed as the number of high
// pwm cycles in a period window; expectations adapt to the soft-start macro.
module tb_motor_drive;

    localparam int P    = 50;
    localparam int TURN = 20;
    localparam int SLW  = 15;
    localparam int MED  = 30;
    localparam int FST  = 45;
`ifdef MOTOR_DRIVE_SOFT_START_EN
    localparam int STEP = 5;
`else
    localparam int STEP = 4096;
`endif

    logic       clk_50 = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] drive_state = 3'b000;
    logic       mode_change = 1'b0;
    logic       left_pwm, left_dir, right_pwm, right_dir, at_target;

    int n_assert = 0;
    int n_fail   = 0;
    int ecount   = 0;

    motor_drive #(
        .PWM_PERIOD  (P),
        .DUTY_W      (12),
        .TURN_DUTY   (TURN),
        .SLOW_DUTY   (SLW),
        .MEDIUM_DUTY (MED),
        .FAST_DUTY   (FST),
        .RAMP_STEP   (5)
    ) dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .drive_state (drive_state),
        .mode_change (mode_change),
        .left_pwm    (left_pwm),
        .left_dir    (left_dir),
        .right_pwm   (right_pwm),
        .right_dir   (right_dir),
        .at_target   (at_target)
    );

    always #10 clk_50 = ~clk_50;

    // Edges since reset release; ecount % P == 0 marks a period boundary.
    always @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) ecount <= 0;
        else          ecount <= ecount + 1;
    end

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int nsteps(input int d);
        return (d + STEP - 1) / STEP;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic align();
        while (ecount % P != 0) step(1);
    endtask

    // Count pwm high cycles over one full period; dir/at_target sampled mid-period.
    task automatic measure(output int lh, output int rh, output int ld, output int rd, output int at);
        lh = 0; rh = 0; ld = 0; rd = 0; at = 0;
        for (int i = 1; i <= P; i++) begin
            @(posedge clk_50);
            #1;
            lh += int'(left_pwm);
            rh += int'(right_pwm);
            if (i == P / 2) begin
                ld = int'(left_dir);
                rd = int'(right_dir);
                at = int'(at_target);
            end
        end
    endtask

    task automatic check_win(input string tag, input int el, input int er,
                             input int edl, input int edr, input int eat);
        int lh, rh, ld, rd, at;
        measure(lh, rh, ld, rd, at);
        $display("win %s: lhigh=%0d rhigh=%0d ldir=%0d rdir=%0d at=%0d", tag, lh, rh, ld, rd, at);
        chk({tag, "_lhigh"}, lh, el);
        chk({tag, "_rhigh"}, rh, er);
        chk({tag, "_ldir"}, ld, edl);
        chk({tag, "_rdir"}, rd, edr);
        chk({tag, "_at"}, at, eat);
    endtask

    task automatic settle(input string tag);
        int lh, rh, ld, rd, at;
        at = 0;
        for (int w = 0; w < 60 && at == 0; w++) measure(lh, rh, ld, rd, at);
        $display("settle %s: at=%0d", tag, at);
        chk({tag, "_settled"}, at, 1);
    endtask

    initial begin
        int nl, nt, el, edl;

        // Reset held: outputs at reset values
        #5 reset_n = 1'b0;
        step(3);
        chk("rst_lpwm", int'(left_pwm), 0);
        chk("rst_rpwm", int'(right_pwm), 0);
        chk("rst_ldir", int'(left_dir), 1);
        chk("rst_rdir", int'(right_dir), 1);
        chk("rst_at", int'(at_target), 1);

        // Release with STOP: three idle periods
        @(negedge clk_50) reset_n = 1'b1;
        for (int i = 0; i < 3; i++) check_win($sformatf("idle%0d", i), 0, 0, 1, 1, 1);

        // STOP -> FAST
        drive_state = 3'b101;
        check_win("fast_w0", 0, 0, 1, 1, 0);
        for (int i = 1; i <= nsteps(FST); i++)
            check_win($sformatf("fast_w%0d", i), imin(i * STEP, FST), imin(i * STEP, FST),
                      1, 1, int'(i == nsteps(FST)));

        // FAST -> LEFT: left reverses through zero and one FLIP period
        drive_state = 3'b001;
        check_win("left_w0", FST, FST, 1, 1, 0);
        nl = nsteps(FST);
        nt = nsteps(TURN);
        for (int i = 1; i <= nl + 1 + nt; i++) begin
            if (i <= nl) begin
                el = imax(FST - i * STEP, 0); edl = 1;
            end else if (i == nl + 1) begin
                el = 0; edl = 0;
            end else begin
                el = imin((i - nl - 1) * STEP, TURN); edl = 0;
            end
            check_win($sformatf("left_w%0d", i), el, imax(FST - i * STEP, TURN),
                      edl, 1, int'(i == nl + 1 + nt));
        end

        // MEDIUM cruising, then a mode_change pulse mid-period
        drive_state = 3'b100;
        settle("medium");
        check_win("medium_cruise", MED, MED, 1, 1, 1);
        step(5);
        chk("mc_pre_lpwm", int'(left_pwm), 1);
        chk("mc_pre_rpwm", int'(right_pwm), 1);
        mode_change = 1'b1;
        step(1);
        mode_change = 1'b0;
        chk("mc_lpwm", int'(left_pwm), 0);
        chk("mc_rpwm", int'(right_pwm), 0);
        step(1);
        chk("mc_at", int'(at_target), 0);
        chk("mc_lpwm_held", int'(left_pwm), 0);
        align();
        check_win("mc_w1", imin(STEP, MED), imin(STEP, MED), 1, 1, int'(STEP >= MED));

        // SLOW, then unused code 110 behaves as STOP
        drive_state = 3'b011;
        settle("slow");
        check_win("slow_cruise", SLW, SLW, 1, 1, 1);
        drive_state = 3'b110;
        check_win("code6_w0", SLW, SLW, 1, 1, 0);
        for (int i = 1; i <= nsteps(SLW); i++)
            check_win($sformatf("code6_w%0d", i), imax(SLW - i * STEP, 0), imax(SLW - i * STEP, 0),
                      1, 1, int'(i == nsteps(SLW)));

        // Asynchronous reset mid-period while pivoting left
        drive_state = 3'b001;
        settle("left2");
        drive_state = 3'b101;
        step(4);
        chk("prerst_lpwm", int'(left_pwm), 1);
        chk("prerst_ldir", int'(left_dir), 0);
        chk("prerst_at", int'(at_target), 0);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_lpwm", int'(left_pwm), 0);
        chk("arst_rpwm", int'(right_pwm), 0);
        chk("arst_ldir", int'(left_dir), 1);
        chk("arst_at", int'(at_target), 1);
        drive_state = 3'b000;
        @(negedge clk_50) reset_n = 1'b1;
        check_win("post_rst", 0, 0, 1, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
